dl_rr_arb16: RTL and testbench

- 16-requester round-robin arbiter with burst lock and a one-entry registered output stage.
- Selects one of 16 valid/ready request streams and forwards its data through a 16:1 selection into a registered output.
- Shares a single downstream consumer (e.g. a memory/bus port) among up to 16 sources in the design library.
- Emits the 4-bit source index alongside each beat.

---
 rtl/dl_rr_arb16.sv | 133 +++++++++++++
 tb/tb_dl_rr_arb16.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_rr_arb16.sv
// dl_rr_arb16: 16-requester round-robin arbiter with burst lock and a
// one-entry registered output stage.
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/in_data/in_last/in_ready  16 valid/ready request streams
//   out_valid/out_data/out_src/out_last/out_ready  registered output beat
//   locked          high while a multi-beat burst holds the grant
module dl_rr_arb16 #(
  parameter int unsigned NUM_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             in_valid,
  input  logic [16*NUM_BITS-1:0]  in_data,
  input  logic [15:0]             in_last,
  output logic [15:0]             in_ready,
  output logic                    out_valid,
  output logic [NUM_BITS-1:0]     out_data,
  output logic [3:0]              out_src,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    locked
);

  localparam int unsigned NUM_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]          state, state_d;
  logic [IDX_W-1:0]    ptr, ptr_d;
  logic [IDX_W-1:0]    lock_src, lock_src_d;
  logic [IDX_W-1:0]    cand, scan_idx, sel;
  logic                cand_found;
  logic                load, accept;
  logic [NUM_BITS-1:0] sel_data;
  logic                sel_last;

  // First valid requester in circular order starting at ptr.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = ptr + IDX_W'(i);
      if (!cand_found && in_valid[scan_idx]) begin
        cand_found = 1'b1;
        cand       = scan_idx;
      end
    end
  end

  // Next-state, grant and pointer update.
  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    lock_src_d = lock_src;
    sel        = cand;
    accept     = 1'b0;
    in_ready   = '0;
    load       = !out_valid || out_ready;
    case (state)
      ST_ARB: begin
        sel    = cand;
        accept = load && cand_found;
        if (accept) begin
          if (in_last[cand]) begin
            ptr_d = cand + IDX_W'(1);
          end else begin
            state_d    = ST_LOCK;
            lock_src_d = cand;
          end
        end
      end
      default: begin
        // Only the burst owner may be granted; idle cycles keep the lock.
        sel    = lock_src;
        accept = load && in_valid[lock_src];
        if (accept && in_last[lock_src]) begin
          state_d = ST_ARB;
          ptr_d   = lock_src + IDX_W'(1);
        end
      end
    endcase
    if (accept) begin
      in_ready[sel] = 1'b1;
    end
  end

  // 16:1 data/last selection of the granted requester.
  always_comb begin
    sel_data = '0;
    sel_last = in_last[sel];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_data = in_data[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // Arbiter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ARB;
      ptr      <= '0;
      lock_src <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      lock_src <= lock_src_d;
      locked   <= (state_d == ST_LOCK);
    end
  end

  // Output register: load on accept, drain when the slot frees with no accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= sel;
      out_last  <= sel_last;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dl_rr_arb16.sv
// Directed self-checking bench for dl_rr_arb16.
module tb_dl_rr_arb16;

  localparam int unsigned NB = 32;

  logic              clk;
  logic              rst_n;
  logic [15:0]       in_valid;
  logic [16*NB-1:0]  in_data;
  logic [15:0]       in_last;
  logic [15:0]       in_ready;
  logic              out_valid;
  logic [NB-1:0]     out_data;
  logic [3:0]        out_src;
  logic              out_last;
  logic              out_ready;
  logic              locked;

  int checks;
  int failures;

  dl_rr_arb16 #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
    .out_ready(out_ready), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [NB-1:0] v);
    in_data[idx*NB +: NB] = v;
  endtask

  task automatic do_reset();
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || out_src !== 4'd0 || out_data !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%0b locked=%0b out_src=%0d out_data=%h out_last=%0b, required all 0",
               out_valid, locked, out_src, out_data, out_last);
    end
    tick();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 16'h0 || locked !== 1'b0 || out_src !== 4'd0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: out_valid=%0b in_ready=%h locked=%0b out_src=%0d, required 0/0000/0/0",
                 c, out_valid, in_ready, locked, out_src);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 16; i++) set_word(i, NB'(32'h100 + i));
    in_last  = 16'hFFFF;
    in_valid = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      #1;
      checks++;
      if (in_ready !== (16'h1 << (k % 16))) begin
        failures++;
        $display("FAIL rr_ready[%0d]: in_ready=%h required %h", k, in_ready, 16'h1 << (k % 16));
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 4'(k % 16) || out_data !== NB'(32'h100 + (k % 16)) || out_last !== 1'b1) begin
        failures++;
        $display("FAIL rr_out[%0d]: valid=%0b src=%0d data=%h last=%0b required 1/%0d/%h/1",
                 k, out_valid, out_src, out_data, out_last, k % 16, 32'h100 + (k % 16));
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_wrap_skip();
    logic [3:0]  exp_src [3];
    logic [15:0] exp_rdy [3];
    exp_src[0] = 4'd0; exp_src[1] = 4'd3; exp_src[2] = 4'd0;
    exp_rdy[0] = 16'h0001; exp_rdy[1] = 16'h0008; exp_rdy[2] = 16'h0001;
    do_reset();
    for (int i = 0; i < 16; i++) set_word(i, NB'(32'h300 + i));
    in_last  = 16'hFFFF;
    in_valid = 16'h2000;
    tick();
    checks++;
    if (out_src !== 4'd13 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_setup: out_src=%0d out_valid=%0b required 13/1", out_src, out_valid);
    end
    in_valid = 16'h0009;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (in_ready !== exp_rdy[k]) begin
        failures++;
        $display("FAIL wrap_ready[%0d]: in_ready=%h required %h", k, in_ready, exp_rdy[k]);
      end
      tick();
      checks++;
      if (out_src !== exp_src[k] || out_data !== NB'(32'h300 + 32'(exp_src[k]))) begin
        failures++;
        $display("FAIL wrap_out[%0d]: out_src=%0d out_data=%h required %0d/%h",
                 k, out_src, out_data, exp_src[k], 32'h300 + 32'(exp_src[k]));
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    in_last   = 16'hFFFF;
    set_word(5, 32'hDEADBEEF);
    set_word(6, 32'h0000_0066);
    in_valid  = 16'h0020;
    #1;
    checks++;
    if (in_ready !== 16'h0020) begin
      failures++;
      $display("FAIL bp_first_ready: in_ready=%h required 0020", in_ready);
    end
    tick();
    in_valid = 16'h0040;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (in_ready !== 16'h0) begin
        failures++;
        $display("FAIL bp_ready[%0d]: in_ready=%h required 0000", c, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_src !== 4'd5 || out_last !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%0b data=%h src=%0d last=%0b required 1/deadbeef/5/1",
                 c, out_valid, out_data, out_src, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 16'h0040) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%h required 0040", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 4'd6 || out_data !== 32'h66) begin
      failures++;
      $display("FAIL bp_next_beat: valid=%0b src=%0d data=%h required 1/6/00000066", out_valid, out_src, out_data);
    end
    in_valid = '0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_src !== 4'd6 || out_data !== 32'h66) begin
      failures++;
      $display("FAIL bp_drain: valid=%0b src=%0d data=%h required 0/6/00000066", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    set_word(1, 32'h0000_0111);
    in_last  = 16'h0002;
    in_valid = 16'h0002;
    tick();
    // ptr now 2; req 2 starts a 3-beat burst, req 1 stays valid throughout
    in_valid = 16'h0006;
    for (int b = 0; b < 3; b++) begin
      set_word(2, NB'(32'h200 + b));
      in_last = (b == 2) ? 16'h0006 : 16'h0002;
      #1;
      checks++;
      if (in_ready !== 16'h0004) begin
        failures++;
        $display("FAIL lock_ready[%0d]: in_ready=%h required 0004", b, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 4'd2 || out_data !== NB'(32'h200 + b) || locked !== (b != 2)) begin
        failures++;
        $display("FAIL lock_beat[%0d]: valid=%0b src=%0d data=%h locked=%0b required 1/2/%h/%0b",
                 b, out_valid, out_src, out_data, locked, 32'h200 + b, b != 2);
      end
      if (b == 0) begin
        // idle cycle from the owner: lock held, req 1 still blocked
        in_valid = 16'h0002;
        #1;
        checks++;
        if (in_ready !== 16'h0) begin
          failures++;
          $display("FAIL lock_idle_ready: in_ready=%h required 0000", in_ready);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL lock_idle: locked=%0b out_valid=%0b required 1/0", locked, out_valid);
        end
        in_valid = 16'h0006;
      end
    end
    in_last = 16'h0006;
    #1;
    checks++;
    if (in_ready !== 16'h0002) begin
      failures++;
      $display("FAIL lock_after_ready: in_ready=%h required 0002", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 4'd1 || out_data !== 32'h111 || locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_after: src=%0d data=%h locked=%0b required 1/00000111/0", out_src, out_data, locked);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_word(7, 32'h0000_0777);
    set_word(3, 32'h0000_0333);
    in_last  = 16'h0000;
    in_valid = 16'h0080;
    tick();
    checks++;
    if (locked !== 1'b1 || out_src !== 4'd7 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ar_first_beat: locked=%0b src=%0d valid=%0b required 1/7/1", locked, out_src, out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || out_src !== 4'd0) begin
      failures++;
      $display("FAIL ar_immediate: out_valid=%0b locked=%0b out_src=%0d required 0/0/0", out_valid, locked, out_src);
    end
    tick();
    #1 rst_n = 1'b1;
    in_last  = 16'h0088;
    in_valid = 16'h0088;
    #1;
    checks++;
    if (in_ready !== 16'h0008) begin
      failures++;
      $display("FAIL ar_resume_ready: in_ready=%h required 0008", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 4'd3 || out_data !== 32'h333 || locked !== 1'b0) begin
      failures++;
      $display("FAIL ar_resume: src=%0d data=%h locked=%0b required 3/00000333/0", out_src, out_data, locked);
    end
    in_valid = '0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_backpressure();
    test_burst_lock();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
